// File: rtl/magnitude_comparator_seq_pkg.sv
// rtl/magnitude_comparator_seq_pkg.sv - shared types, result encoding and sizing helper for the sequential comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } cmp_state_e;

    localparam logic [1:0] GT = 2'd0;
    localparam logic [1:0] EQ = 2'd1;
    localparam logic [1:0] LT = 2'd2;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/magnitude_comparator_seq_if.sv
// rtl/magnitude_comparator_seq_if.sv - start/busy/done request and result bundle for the sequential comparator
interface magnitude_comparator_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             a_gt_b;
    logic             a_eq_b;
    logic             a_lt_b;

    modport master (
        output start, signed_mode, a, b,
        input  busy, done, a_gt_b, a_eq_b, a_lt_b
    );

    modport slave (
        input  start, signed_mode, a, b,
        output busy, done, a_gt_b, a_eq_b, a_lt_b
    );
endinterface

// File: rtl/magnitude_comparator_seq_chunk.sv
// rtl/magnitude_comparator_seq_chunk.sv - combinational unsigned compare of one CHUNK-bit slice
module comparator_chunk #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);
    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);
endmodule

// File: rtl/magnitude_comparator_seq.sv
// rtl/magnitude_comparator_seq.sv - multi-cycle MSB-chunk-first magnitude comparator; CMP_EARLY_EXIT_EN finishes on the first differing chunk
module magnitude_comparator_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    magnitude_comparator_seq_if.slave  bus
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_COMPARE = COMPARE;
    localparam logic [1:0] ST_DONE    = DONE;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic             mode_r;
    logic             dec_valid;
    logic [1:0]       dec_res;
    logic             gt_r;
    logic             eq_r;
    logic             lt_r;

    logic [WIDTH-1:0] sign_mask;
    logic [WIDTH-1:0] a_cmp;
    logic [WIDTH-1:0] b_cmp;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic             c_gt;
    logic             c_eq;
    logic             c_lt;
    logic [1:0]       chunk_res;
    logic [1:0]       res_next;
    logic             hit;
    logic             last;
    logic             finish;

    // Flipping both sign bits maps two's-complement order onto unsigned order.
    assign sign_mask = {mode_r, {(WIDTH-1){1'b0}}};
    assign a_cmp     = a_r ^ sign_mask;
    assign b_cmp     = b_r ^ sign_mask;
    assign a_shift   = a_cmp >> (idx * CHUNK);
    assign b_shift   = b_cmp >> (idx * CHUNK);
    assign a_chunk   = a_shift[CHUNK-1:0];
    assign b_chunk   = b_shift[CHUNK-1:0];

    comparator_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a  (a_chunk),
        .b  (b_chunk),
        .gt (c_gt),
        .eq (c_eq),
        .lt (c_lt)
    );

    assign chunk_res = c_gt ? GT : (c_lt ? LT : EQ);
    assign res_next  = dec_valid ? dec_res : chunk_res;
    assign hit       = !dec_valid && !c_eq;
    assign last      = (idx == '0);

`ifdef CMP_EARLY_EXIT_EN
    assign finish = last || hit;
`else
    assign finish = last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            mode_r    <= 1'b0;
            dec_valid <= 1'b0;
            dec_res   <= EQ;
            gt_r      <= 1'b0;
            eq_r      <= 1'b0;
            lt_r      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        a_r       <= bus.a;
                        b_r       <= bus.b;
                        mode_r    <= bus.signed_mode;
                        idx       <= IDX_W'(NCHUNK - 1);
                        dec_valid <= 1'b0;
                        dec_res   <= EQ;
                        gt_r      <= 1'b0;
                        eq_r      <= 1'b0;
                        lt_r      <= 1'b0;
                        state     <= ST_COMPARE;
                    end else if (state == ST_DONE) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COMPARE: begin
                    // Only the first differing chunk decides; later chunks are ignored.
                    if (hit) begin
                        dec_valid <= 1'b1;
                        dec_res   <= chunk_res;
                    end
                    if (finish) begin
                        gt_r  <= (res_next == GT);
                        eq_r  <= (res_next == EQ);
                        lt_r  <= (res_next == LT);
                        state <= ST_DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state == ST_COMPARE);
    assign bus.done   = (state == ST_DONE);
    assign bus.a_gt_b = gt_r;
    assign bus.a_eq_b = eq_r;
    assign bus.a_lt_b = lt_r;

endmodule

// File: tb/tb_magnitude_comparator_seq.sv
// tb/tb_magnitude_comparator_seq.sv - directed self-checking bench for magnitude_comparator_seq (WIDTH=8, CHUNK=2)
module tb_magnitude_comparator_seq;

    localparam logic [2:0] F_GT = 3'b100;
    localparam logic [2:0] F_EQ = 3'b010;
    localparam logic [2:0] F_LT = 3'b001;

    logic clk;
    logic rst;
    int   checks;
    int   passes;

    magnitude_comparator_seq_if #(.WIDTH(8)) bus ();

    magnitude_comparator_seq #(
        .WIDTH (8),
        .CHUNK (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [2:0] flags();
        return {bus.a_gt_b, bus.a_eq_b, bus.a_lt_b};
    endfunction

    task automatic accept(input logic [7:0] a, input logic [7:0] b, input logic m);
        @(negedge clk);
        bus.a           = a;
        bus.b           = b;
        bus.signed_mode = m;
        bus.start       = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // lat counts edges since the accept edge; call at #1 after edge number lat0.
    task automatic wait_done(input string tag, input int lat0, output int lat, output logic [2:0] f);
        bit seen;
        seen = 0;
        lat  = lat0;
        f    = 3'b000;
        while (!seen && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bus.done) begin
                seen = 1;
                f    = flags();
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic m,
                          input int exp_lat, input logic [2:0] exp_f);
        int         lat;
        logic [2:0] f;
        accept(a, b, m);
        wait_done(tag, 0, lat, f);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_flags"}, f, exp_f);
    endtask

    int         lat;
    logic [2:0] f;
    int         dcount;
    int         dtimes[$];
    logic [2:0] dflags[$];

    initial begin
        checks          = 0;
        passes          = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a           = '0;
        bus.b           = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_flags", flags(), 0);

        run_op("eq_a5", 8'hA5, 8'hA5, 1'b0, 4, F_EQ);

        // Flags persist through IDLE.
        repeat (3) @(negedge clk);
        check("hold_done", bus.done, 0);
        check("hold_flags", flags(), F_EQ);

        run_op("u_80_7f", 8'h80, 8'h7F, 1'b0, 4, F_GT);
        run_op("s_80_7f", 8'h80, 8'h7F, 1'b1, 4, F_LT);
        run_op("u_01_02", 8'h01, 8'h02, 1'b0, 4, F_LT);
        run_op("s_ff_fe", 8'hFF, 8'hFE, 1'b1, 4, F_GT);
`ifdef CMP_EARLY_EXIT_EN
        run_op("u_c0_00", 8'hC0, 8'h00, 1'b0, 1, F_GT);
        run_op("u_04_08", 8'h04, 8'h08, 1'b0, 3, F_LT);
`else
        run_op("u_c0_00", 8'hC0, 8'h00, 1'b0, 4, F_GT);
        run_op("u_04_08", 8'h04, 8'h08, 1'b0, 4, F_LT);
`endif

        // start during COMPARE must not re-capture operands.
        accept(8'h10, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        check("ign_busy", bus.busy, 1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("ign", 2, lat, f);
        check("ign_lat", lat, 4);
        check("ign_flags", f, F_LT);

        // Reset mid-operation aborts without a done pulse.
        accept(8'h33, 8'h11, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_flags", flags(), 0);

        // Back-to-back with start held high.
        @(negedge clk);
        bus.a           = 8'h3C;
        bus.b           = 8'h3B;
        bus.signed_mode = 1'b0;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.a           = 8'hFF;
        bus.b           = 8'h01;
        bus.signed_mode = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            @(posedge clk);
            #1;
            if (t == 5) begin
                bus.a           = 8'h7E;
                bus.b           = 8'h7E;
                bus.signed_mode = 1'b1;
            end
            if (t == 10) bus.start = 1'b0;
            @(negedge clk);
            if (bus.done) begin
                dtimes.push_back(t);
                dflags.push_back(flags());
            end
        end
        check("b2b_count", dtimes.size(), 3);
        if (dtimes.size() == 3) begin
            check("b2b_t0", dtimes[0], 4);
            check("b2b_t1", dtimes[1], 9);
            check("b2b_t2", dtimes[2], 14);
            check("b2b_f0", dflags[0], F_GT);
            check("b2b_f1", dflags[1], F_LT);
            check("b2b_f2", dflags[2], F_EQ);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Whenever done is high exactly one flag must be set.
    always @(negedge clk) begin
        if (!rst && bus.done) check("onehot", $countones(flags()), 1);
    end

endmodule

// File: doc/magnitude_comparator_seq.md
# magnitude_comparator_seq

Parametrised, multi-cycle magnitude comparator: the successor to the fixed-width combinational comparators in the arithmetic-circuits set. It compares two WIDTH-bit operands CHUNK bits per clock, MSB chunk first, and supports unsigned or two's-complement signed comparison selected per operation. A start/busy/done handshake lets it sit beside other sequential arithmetic blocks, such as serial adders and multipliers, trading latency for area.

## Interface
- WIDTH, 8, operand width in bits; must be a multiple of CHUNK and at least 2.
- CHUNK, 2, bits compared per cycle; NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or done.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse; the result flags are valid from this cycle.
- a_gt_b  output  1  A > B.
- a_eq_b  output  1  A == B.
- a_lt_b  output  1  A < B.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - COMPARE: busy=1.
  - DONE: done=1.
- Reset: state IDLE; busy, done, a_gt_b, a_eq_b and a_lt_b all 0; internal chunk index and operand registers cleared.
- Accept: start=1 in IDLE or DONE loads a, b and signed_mode into registers, clears all three flags, sets idx=NCHUNK-1 and enters COMPARE.
- start while in COMPARE is ignored; the operands are not re-captured.
- Signed mode: the sign bit (bit WIDTH-1) of both captured operands is inverted before comparison (offset-binary trick), so the chunk compare is always unsigned.
- COMPARE, one chunk per edge, MSB chunk first:
  - On the first differing chunk, latch the decision (gt or lt); later chunks cannot change it.
  - At idx==0, go to DONE and drive the flags: the latched decision, or eq if no chunk differed.
- DONE lasts one cycle, then IDLE, unless start is accepted in DONE (back-to-back operation).
- Flags hold their value through IDLE until the next accept.
- Whenever done=1, exactly one flag is high.

## Timing
- Edge E0 samples start. Edges E1..E(NCHUNK) process chunks NCHUNK-1..0. done=1 and the flags are valid in the cycle after E(NCHUNK).
- Latency: NCHUNK cycles from accept (4 for the defaults).
- Throughput: one result per NCHUNK+1 cycles with start held high.
- rst=1 in any state wins at the next edge and aborts the comparison; no done pulse is produced.
- Operand inputs may change freely after the accept edge.

## Configuration
- CMP_EARLY_EXIT_EN defined:
  - COMPARE moves to DONE on the edge that finds the first differing chunk.
  - Latency = k cycles, where k is the 1-based position of that chunk counted from the MSB end.
  - Equal operands still take NCHUNK cycles.
- Undefined: latency is fixed at NCHUNK for all operands (data-independent timing).
- Flag values are identical with and without the macro.

## Structure
- Package cmp_pkg holds:
  - the state enum (IDLE, COMPARE, DONE);
  - a result encoding localparam (GT, EQ, LT);
  - a NCHUNK helper function.
- Sub-module comparator_chunk: combinational CHUNK-bit unsigned compare with gt/eq/lt outputs, instantiated once and fed by an idx-selected slice.
- Top level holds the FSM, idx counter, operand registers and decision latch.

## Test plan
All scenarios use WIDTH=8, CHUNK=2.
- Reset, then idle: rst high 2 cycles, then low -> busy=0, done=0, all flags 0.
- a=8'hA5, b=8'hA5, signed_mode=0, start 1 cycle -> done exactly 4 cycles after accept; a_eq_b=1, others 0.
- a=8'h80, b=8'h7F, signed_mode=0 -> a_gt_b=1. Same operands with signed_mode=1 -> a_lt_b=1 (-128 < 127).
- a=8'h01, b=8'h02: without CMP_EARLY_EXIT_EN, done after 4 cycles; with it, done after 4 cycles (difference is in the last chunk). a=8'hC0, b=8'h00 with the macro -> done after 1 cycle, a_gt_b=1.
- Abort and ignore: start a=8'h10, b=8'h20; pulse start again with a=8'hFF in cycle 2 -> ignored, result a_lt_b=1. Assert rst in cycle 3 of a fresh operation -> no done, all outputs 0.
- Back-to-back: start held high across 3 operand pairs -> 3 done pulses spaced 5 cycles apart, each with correct flags.
